ksa_multiword_seq: RTL and testbench

//  Sequential multi-word adder built around the 16-bit Kogge-Stone adder (KSA) datapath.

---
 rtl/ksa_multiword_seq_if.sv | 28 ++
 rtl/ksa_multiword_seq.sv | 117 +++++++++++
 tb/tb_ksa_multiword_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ksa_multiword_seq_if.sv
// Operand/result handshake plus the slice bus to the external 16-bit KSA.
// slave is the adder side; master is the producer/consumer that also hosts the KSA.
interface ksa_multiword_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_sum;
    logic [15:0]  ksa_a;
    logic [15:0]  ksa_b;
    logic [16:0]  ksa_s;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, ksa_s,
        output in_ready, out_valid, out_sum, ksa_a, ksa_b
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, ksa_s,
        input  in_ready, out_valid, out_sum, ksa_a, ksa_b
    );
endinterface

// File: rtl/ksa_multiword_seq.sv
// Multi-word adder feeding one 16-bit slice per cycle (LSW first) to an external KSA; result
// valid WORDS+1 cycles after the operand handshake, held indefinitely while out_ready is low.
module ksa_multiword_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    ksa_multiword_seq_if.slave  bus
);
    localparam int W    = 16 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W:0]      res_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [15:0]     slice_a;
    logic [15:0]     slice_b;
    logic [15:0]     sum_lo;
    logic            carry_d;
    logic [W:0]      res_d;

    // Constant-index loops keep every part-select in range, including WORDS=1.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        if (state_q == RUN) begin
            for (int w = 0; w < WORDS; w++) begin
                if (idx_q == IDXW'(w)) begin
                    slice_a = a_q[16*w +: 16];
                    slice_b = b_q[16*w +: 16];
                end
            end
        end
    end

    // The KSA has no carry-in, so the chained carry is added as an increment here.
    always_comb begin
        sum_lo  = bus.ksa_s[15:0] + {15'd0, carry_q};
        carry_d = bus.ksa_s[16] | (carry_q & (bus.ksa_s[15:0] == 16'hFFFF));
        res_d   = res_q;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDXW'(w)) begin
                res_d[16*w +: 16] = sum_lo;
            end
        end
        if (idx_q == LAST) begin
            res_d[W] = carry_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.in_a;
                        b_q        <= bus.in_b;
                        idx_q      <= '0;
                        carry_q    <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    if (idx_q == LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = res_q;
    assign bus.ksa_a     = slice_a;
    assign bus.ksa_b     = slice_b;
endmodule

// File: tb/tb_ksa_multiword_seq.sv
// Scoreboard bench: drivers push expected sums on handshake, monitors pop on each result handshake.
module tb_ksa_multiword_seq;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;
    int   acc4_cyc;
    int   done4_cyc;
    bit   rnd_on;

    logic [64:0] exp4_q[$];
    logic [16:0] exp1_q[$];

    ksa_multiword_seq_if #(.WORDS(4)) if4 ();
    ksa_multiword_seq_if #(.WORDS(1)) if1 ();

    // Behavioural 16-bit KSA for each instance.
    assign if4.ksa_s = {1'b0, if4.ksa_a} + {1'b0, if4.ksa_b};
    assign if1.ksa_s = {1'b0, if1.ksa_a} + {1'b0, if1.ksa_b};

    ksa_multiword_seq #(.WORDS(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
    ksa_multiword_seq #(.WORDS(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && if4.out_valid && if4.out_ready) begin
            if (exp4_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out4_unexpected: got %h required no result", if4.out_sum);
            end else begin
                check("sum4", if4.out_sum, exp4_q.pop_front());
                done4_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if1.out_valid && if1.out_ready) begin
            if (exp1_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out1_unexpected: got %h required no result", if1.out_sum);
            end else begin
                check("sum1", 65'(if1.out_sum), 65'(exp1_q.pop_front()));
            end
        end
    end

    task automatic send4(input logic [63:0] a, input logic [63:0] b, input logic [64:0] exp);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        if4.in_valid = 1'b1;
        if4.in_a     = a;
        if4.in_b     = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (if4.in_ready) begin
                exp4_q.push_back(exp);
                acc4_cyc = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept4_timeout: got in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        if4.in_valid = 1'b0;
    endtask

    task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic [16:0] exp);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        if1.in_valid = 1'b1;
        if1.in_a     = a;
        if1.in_b     = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (if1.in_ready) begin
                exp1_q.push_back(exp);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept1_timeout: got in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        if1.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp4_q.size() == 0 && exp1_q.size() == 0) return;
        end
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d/%0d pending required 0/0", exp4_q.size(), exp1_q.size());
        exp4_q.delete();
        exp1_q.delete();
    endtask

    function automatic logic [15:0] rnd_slice();
        return ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
    endfunction

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rnd_on = 1'b0;
        rst = 1'b1;
        if4.in_valid = 1'b0; if4.in_a = '0; if4.in_b = '0; if4.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 65'(if4.in_ready), 65'd1);
        check("rst_out_valid", 65'(if4.out_valid), 65'd0);
        check("rst_out_sum", if4.out_sum, 65'd0);
        check("rst_ksa_ab", {33'd0, if4.ksa_a, if4.ksa_b}, 65'd0);
        check("rst_out_sum1", 65'(if1.out_sum), 65'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // T1: zero operands, latency and single-cycle out_valid.
        send4(64'h0, 64'h0, 65'h0);
        drain(50);
        check("t1_latency", 65'(done4_cyc - acc4_cyc), 65'd5);
        @(negedge clk);
        check("t1_valid_drop", 65'(if4.out_valid), 65'd0);
        check("t1_ready_back", 65'(if4.in_ready), 65'd1);

        // T2/T3: carry ripple through the increment, and final carry-out.
        send4(64'h0000_FFFF_FFFF_FFFF, 64'h1, 65'h0_0001_0000_0000_0000);
        send4(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE);
        drain(50);

        // T4: backpressure holds the result; next op accepted one cycle after release.
        if4.out_ready = 1'b0;
        send4(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 65'h0_2345_6789_ABCD_F001);
        for (int i = 0; i < 20 && !if4.out_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_sum", if4.out_sum, 65'h0_2345_6789_ABCD_F001);
            check("t4_hold_ready", {63'd0, if4.out_valid, if4.in_ready}, 65'b10);
        end
        @(posedge clk);
        #1;
        if4.out_ready = 1'b1;
        if4.in_valid  = 1'b1;
        if4.in_a      = 64'd3;
        if4.in_b      = 64'd4;
        @(negedge clk);
        check("t4_no_overlap", 65'(if4.in_ready), 65'd0);
        @(negedge clk);
        check("t4_accept_next", 65'(if4.in_ready), 65'd1);
        exp4_q.push_back(65'd7);
        @(posedge clk);
        #1 if4.in_valid = 1'b0;
        drain(50);

        // T5: slice addressing at idx=2, then reset mid-RUN aborts immediately.
        send4(64'h4444_3333_2222_1111, 64'h8888_7777_6666_5555, 65'h0_CCCC_AAAA_8888_6666);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t5_slice2", {33'd0, if4.ksa_a, if4.ksa_b}, {33'd0, 16'h3333, 16'h7777});
        rst = 1'b1;
        exp4_q.delete();
        #1;
        check("t5_rst_now", {45'd0, if4.out_valid, if4.in_ready, if4.ksa_a, if4.ksa_b},
              {45'd0, 1'b0, 1'b1, 16'h0, 16'h0});
        @(negedge clk);
        rst = 1'b0;
        send4(64'd5, 64'd7, 65'hC);
        send1(16'hFFFF, 16'h0001, 17'h1_0000);
        drain(50);

        // T6: random ops on both widths with random out_ready.
        rnd_on = 1'b1;
        fork
            begin
                fork
                    for (int n = 0; n < 1500; n++) begin
                        ra = {rnd_slice(), rnd_slice(), rnd_slice(), rnd_slice()};
                        rb = {rnd_slice(), rnd_slice(), rnd_slice(), rnd_slice()};
                        send4(ra, rb, {1'b0, ra} + {1'b0, rb});
                    end
                    for (int n = 0; n < 2500; n++) begin
                        logic [15:0] sa;
                        logic [15:0] sb;
                        sa = rnd_slice();
                        sb = rnd_slice();
                        send1(sa, sb, {1'b0, sa} + {1'b0, sb});
                    end
                join
                rnd_on = 1'b0;
            end
            while (rnd_on) begin
                @(posedge clk);
                #1;
                if4.out_ready = 1'($urandom_range(0, 1));
                if1.out_ready = 1'($urandom_range(0, 1));
            end
        join
        if4.out_ready = 1'b1;
        if1.out_ready = 1'b1;
        drain(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_500_000;
        fails++;
        $display("FAIL watchdog: got no completion required finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end
endmodule
